// File: rtl/debug_display_sequencer_pkg.sv
// Shared encodings for the debug display sequencer: run/step/halt mode
// values, the LCD handshake state type and a width helper for small counters.
package debug_disp_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OFFER   = 2'd2
    } disp_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_display_sequencer_if.sv
// Snapshot hand-off between the sequencer (master) and the LCD driver (slave).
interface debug_display_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int PAGE_W = 1
);
    logic [DATA_W-1:0] DataX;
    logic [DATA_W-1:0] DataY;
    logic [PAGE_W-1:0] Page;
    logic              UpdValid;
    logic              UpdReady;

    modport master (
        output DataX,
        output DataY,
        output Page,
        output UpdValid,
        input  UpdReady
    );

    modport slave (
        input  DataX,
        input  DataY,
        input  Page,
        input  UpdValid,
        output UpdReady
    );
endinterface

// File: rtl/debug_display_sequencer_tick_div.sv
// Execute-tick source: a free-running divider in run mode, a rising-edge
// detector on the step button in step mode, silence in halt.  Any mode
// change restarts the divider and suppresses the tick for that cycle.
module tick_div
    import debug_disp_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Mode,
    input  logic       StepBtn,
    output logic       Tick
);
    localparam int             DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       mode_q;
    logic             step_q;
    logic             mode_change;

    // Next divider value and tick; divider only moves in an unchanged run mode.
    always_comb begin
        div_d       = '0;
        Tick        = 1'b0;
        mode_change = (Mode != mode_q);
        if (!mode_change) begin
            if (Mode == MODE_RUN) begin
                if (div_q == DIV_LAST) begin
                    Tick = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end else if (Mode == MODE_STEP) begin
                Tick = StepBtn & ~step_q;
            end
        end
    end

    // Divider, last-seen mode and previous button level.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_q  <= '0;
            mode_q <= MODE_RUN;
            step_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            mode_q <= Mode;
            step_q <= StepBtn;
        end
    end
endmodule

// File: rtl/debug_display_sequencer.sv
// Execute-enable generator plus paged debug-word snapshotter for the LCD.
// CpuEn is never held back by the LCD; ticks that arrive while a snapshot is
// still being offered collapse into a single pending re-capture.
module debug_display_sequencer
    import debug_disp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DIV    = 50_000_000,
    parameter int DWELL  = 3
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [1:0]               Mode,
    input  logic                     StepBtn,
    input  logic [NUM_CH*DATA_W-1:0] ChData,
    output logic                     CpuEn,
    debug_display_sequencer_if.master lcd
);
    localparam int NUM_PAGES = NUM_CH / 2;
    localparam int PAGE_W    = width_min1(NUM_PAGES);
    localparam int DWELL_W   = width_min1(DWELL);
    localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic                tick;
    logic                cpu_en_q;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [PAGE_W-1:0]   next_page_q, next_page_d;
    disp_state_e         state_q, state_d;
    logic                pending_q, pending_d;
    logic [DATA_W-1:0]   data_x_q, data_x_d;
    logic [DATA_W-1:0]   data_y_q, data_y_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                upd_valid;
    logic [DATA_W-1:0]   sel_x, sel_y;

    tick_div #(.DIV(DIV)) u_tick_div (
        .Clk     (Clk),
        .Rst     (Rst),
        .Mode    (Mode),
        .StepBtn (StepBtn),
        .Tick    (tick)
    );

    assign sel_x = ChData[2 * int'(next_page_q) * DATA_W +: DATA_W];
    assign sel_y = ChData[(2 * int'(next_page_q) + 1) * DATA_W +: DATA_W];

    // Dwell counting: every DWELL-th execute pulse moves to the next page.
    always_comb begin
        dwell_d     = dwell_q;
        next_page_d = next_page_q;
        if (cpu_en_q) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d     = '0;
                next_page_d = (next_page_q == PAGE_LAST) ? '0 : next_page_q + PAGE_W'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // Handshake FSM: capture on a tick, offer until accepted, re-capture if ticked meanwhile.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        data_x_d  = data_x_q;
        data_y_d  = data_y_q;
        page_d    = page_q;
        upd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_en_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                data_x_d = sel_x;
                data_y_d = sel_y;
                page_d   = next_page_q;
                state_d  = OFFER;
                if (cpu_en_q) begin
                    pending_d = 1'b1;
                end
            end
            OFFER: begin
                upd_valid = 1'b1;
                if (lcd.UpdReady) begin
                    if (pending_q || cpu_en_q) begin
                        state_d   = CAPTURE;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cpu_en_q) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer state, cleared asynchronously.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cpu_en_q    <= 1'b0;
            dwell_q     <= '0;
            next_page_q <= '0;
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            data_x_q    <= '0;
            data_y_q    <= '0;
            page_q      <= '0;
        end else begin
            cpu_en_q    <= tick;
            dwell_q     <= dwell_d;
            next_page_q <= next_page_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            data_x_q    <= data_x_d;
            data_y_q    <= data_y_d;
            page_q      <= page_d;
        end
    end

    assign CpuEn        = cpu_en_q;
    assign lcd.UpdValid = upd_valid;
    assign lcd.DataX    = data_x_q;
    assign lcd.DataY    = data_y_q;
    assign lcd.Page     = page_q;
endmodule

// File: tb/tb_debug_display_sequencer.sv
// Bench for debug_display_sequencer: two instances (4 channels / dwell 2 and
// 8 channels / dwell 1) fed with random channel words every cycle.  Expected
// pulse times, pages and snapshot words come from arithmetic on tick counts
// and from the bench's own record of what it drove on ChData.
module tb_debug_display_sequencer;
    import debug_disp_pkg::*;

    localparam int NCH_A = 4, DW_A = 32, DIV_A = 4, DWELL_A = 2, PAGES_A = 2;
    localparam int NCH_B = 8, DW_B = 16, DIV_B = 3, DWELL_B = 1, PAGES_B = 4;
    localparam int PW_A = width_min1(PAGES_A);
    localparam int PW_B = width_min1(PAGES_B);
    localparam int HIST = 64;

    logic                   Clk = 1'b0;
    logic                   Rst = 1'b1;
    logic [1:0]             Mode = MODE_RUN;
    logic                   StepBtn = 1'b0;
    logic [NCH_A*DW_A-1:0]  ch_a = '0;
    logic [NCH_B*DW_B-1:0]  ch_b = '0;
    logic                   ready_a = 1'b1;
    logic                   ready_b = 1'b1;
    logic                   cpu_en_a, cpu_en_b;
    logic [NCH_A*DW_A-1:0]  hist_a [HIST];
    logic [NCH_B*DW_B-1:0]  hist_b [HIST];
    int                     cyc = 0;
    int                     n_checks = 0;
    int                     n_pass = 0;

    debug_display_sequencer_if #(.DATA_W(DW_A), .PAGE_W(PW_A)) if_a ();
    debug_display_sequencer_if #(.DATA_W(DW_B), .PAGE_W(PW_B)) if_b ();
    assign if_a.UpdReady = ready_a;
    assign if_b.UpdReady = ready_b;

    debug_display_sequencer #(.NUM_CH(NCH_A), .DATA_W(DW_A), .DIV(DIV_A), .DWELL(DWELL_A)) dut_a (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .StepBtn(StepBtn), .ChData(ch_a), .CpuEn(cpu_en_a), .lcd(if_a)
    );
    debug_display_sequencer #(.NUM_CH(NCH_B), .DATA_W(DW_B), .DIV(DIV_B), .DWELL(DWELL_B)) dut_b (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .StepBtn(StepBtn), .ChData(ch_b), .CpuEn(cpu_en_b), .lcd(if_b)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW_A-1:0] word_a(input int c, input int ch);
        return hist_a[c % HIST][ch*DW_A +: DW_A];
    endfunction

    function automatic logic [DW_B-1:0] word_b(input int c, input int ch);
        return hist_b[c % HIST][ch*DW_B +: DW_B];
    endfunction

    // Step button level the bench applies during cycle c.
    function automatic logic step_level(input int c);
        return ((c >= 3) && (c <= 12)) || ((c >= 16) && (c <= 18));
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NCH_A*DW_A/32; i++) ch_a[i*32 +: 32] = $urandom();
        for (int i = 0; i < NCH_B*DW_B/32; i++) ch_b[i*32 +: 32] = $urandom();
    endtask

    // One clock: new random channel words just after the edge, return at the falling edge.
    task automatic advance();
        @(posedge Clk);
        #1;
        cyc++;
        fill_random();
        hist_a[cyc % HIST] = ch_a;
        hist_b[cyc % HIST] = ch_b;
        @(negedge Clk);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        cyc = 0;
        fill_random();
        hist_a[0] = ch_a;
        hist_b[0] = ch_b;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic rdy);
        Rst = 1'b0;
        Mode = m;
        StepBtn = 1'b0;
        ready_a = rdy;
        ready_b = 1'b1;
        release_reset();
    endtask

    task automatic test_reset();
        #2 Rst = 1'b0;
        #1;
        n_checks++; if ({cpu_en_a, if_a.UpdValid, if_a.DataX, if_a.DataY, if_a.Page} !== '0)
            $display("[TB] FAIL reset_a: got %0h required 0", {cpu_en_a, if_a.UpdValid, if_a.DataX, if_a.DataY, if_a.Page}); else n_pass++;
        n_checks++; if ({cpu_en_b, if_b.UpdValid, if_b.DataX, if_b.DataY, if_b.Page} !== '0)
            $display("[TB] FAIL reset_b: got %0h required 0", {cpu_en_b, if_b.UpdValid, if_b.DataX, if_b.DataY, if_b.Page}); else n_pass++;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if ({cpu_en_a, if_a.UpdValid} !== 2'b00)
            $display("[TB] FAIL reset_held_a: got %0b required 00", {cpu_en_a, if_a.UpdValid}); else n_pass++;
        release_reset();
    endtask

    // Run mode straight after reset: pulses every DIV cycles, offers two cycles later.
    task automatic test_run();
        int c, n, pg;
        for (int i = 0; i < 40; i++) begin
            advance();
            c = cyc;
            n_checks++; if (cpu_en_a !== ((c % DIV_A) == 0))
                $display("[TB] FAIL run_cpu_en_a c=%0d: got %0b required %0b", c, cpu_en_a, (c % DIV_A) == 0); else n_pass++;
            n_checks++; if (if_a.UpdValid !== ((c >= DIV_A + 2) && ((c - 2) % DIV_A == 0)))
                $display("[TB] FAIL run_valid_a c=%0d: got %0b", c, if_a.UpdValid); else n_pass++;
            if ((c >= DIV_A + 2) && ((c - 2) % DIV_A == 0)) begin
                n = (c - 2) / DIV_A;
                pg = (n / DWELL_A) % PAGES_A;
                n_checks++; if (if_a.Page !== PW_A'(pg))
                    $display("[TB] FAIL run_page_a c=%0d: got %0d required %0d", c, if_a.Page, pg); else n_pass++;
                n_checks++; if ({if_a.DataX, if_a.DataY} !== {word_a(c - 1, 2*pg), word_a(c - 1, 2*pg + 1)})
                    $display("[TB] FAIL run_data_a c=%0d: got %0h/%0h required %0h/%0h", c, if_a.DataX, if_a.DataY,
                             word_a(c - 1, 2*pg), word_a(c - 1, 2*pg + 1)); else n_pass++;
            end
            n_checks++; if (cpu_en_b !== ((c % DIV_B) == 0))
                $display("[TB] FAIL run_cpu_en_b c=%0d: got %0b required %0b", c, cpu_en_b, (c % DIV_B) == 0); else n_pass++;
            n_checks++; if (if_b.UpdValid !== ((c >= DIV_B + 2) && ((c - 2) % DIV_B == 0)))
                $display("[TB] FAIL run_valid_b c=%0d: got %0b", c, if_b.UpdValid); else n_pass++;
            if ((c >= DIV_B + 2) && ((c - 2) % DIV_B == 0)) begin
                n = (c - 2) / DIV_B;
                pg = (n / DWELL_B) % PAGES_B;
                n_checks++; if (if_b.Page !== PW_B'(pg))
                    $display("[TB] FAIL wrap_page_b c=%0d: got %0d required %0d", c, if_b.Page, pg); else n_pass++;
                n_checks++; if ({if_b.DataX, if_b.DataY} !== {word_b(c - 1, 2*pg), word_b(c - 1, 2*pg + 1)})
                    $display("[TB] FAIL wrap_data_b c=%0d: got %0h/%0h required %0h/%0h", c, if_b.DataX, if_b.DataY,
                             word_b(c - 1, 2*pg), word_b(c - 1, 2*pg + 1)); else n_pass++;
            end
        end
    endtask

    // Step mode: one pulse per button rising edge, nothing while it is held.
    task automatic test_step();
        int c, pulses, doubles;
        logic prev, expv;
        pulses = 0;
        doubles = 0;
        prev = 1'b0;
        do_reset(MODE_STEP, 1'b1);
        for (int i = 0; i < 30; i++) begin
            advance();
            c = cyc;
            expv = step_level(c - 1) && !step_level(c - 2);
            n_checks++; if (cpu_en_a !== expv)
                $display("[TB] FAIL step_cpu_en c=%0d: got %0b required %0b", c, cpu_en_a, expv); else n_pass++;
            if (cpu_en_a === 1'b1) pulses++;
            if (cpu_en_a === 1'b1 && prev) doubles++;
            prev = cpu_en_a;
            StepBtn = step_level(c);
        end
        n_checks++; if (pulses !== 2)
            $display("[TB] FAIL step_pulse_count: got %0d required 2", pulses); else n_pass++;
        n_checks++; if (doubles !== 0)
            $display("[TB] FAIL step_pulse_width: got %0d back-to-back pulses required 0", doubles); else n_pass++;
    endtask

    // Halt after three run ticks, then resume and time the first pulse.
    task automatic test_halt();
        int pulses, k;
        pulses = 0;
        do_reset(MODE_RUN, 1'b1);
        for (int i = 0; i < 3*DIV_A; i++) begin
            advance();
            if (cpu_en_a === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 3)
            $display("[TB] FAIL halt_run_ticks: got %0d required 3", pulses); else n_pass++;
        Mode = MODE_HALT;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            advance();
            if (i == 10) Mode = 2'b11;
            if (cpu_en_a === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0)
            $display("[TB] FAIL halt_no_ticks: got %0d pulses required 0", pulses); else n_pass++;
        n_checks++; if ({if_a.UpdValid, if_a.Page} !== {1'b0, PW_A'((3 / DWELL_A) % PAGES_A)})
            $display("[TB] FAIL halt_page_frozen: got valid/page %0b/%0d required 0/%0d", if_a.UpdValid, if_a.Page,
                     (3 / DWELL_A) % PAGES_A); else n_pass++;
        // Change is seen this cycle, divider restarts from 0 at the next edge, pulse DIV edges after that.
        Mode = MODE_RUN;
        k = 0;
        for (int i = 0; i < 3*DIV_A; i++) begin
            advance();
            k++;
            if (cpu_en_a === 1'b1) break;
        end
        n_checks++; if (k !== DIV_A + 1)
            $display("[TB] FAIL halt_resume_latency: got %0d cycles required %0d", k, DIV_A + 1); else n_pass++;
    endtask

    // LCD stalls through three ticks; one coalesced re-capture follows acceptance.
    task automatic test_backpressure();
        int c;
        int r;
        r = 3*DIV_A + 1;
        do_reset(MODE_RUN, 1'b0);
        for (int i = 0; i < r; i++) begin
            advance();
            c = cyc;
            if (c >= DIV_A + 2) begin
                n_checks++; if ({if_a.UpdValid, if_a.Page, if_a.DataX, if_a.DataY} !==
                                {1'b1, PW_A'(0), word_a(DIV_A + 1, 0), word_a(DIV_A + 1, 1)})
                    $display("[TB] FAIL bp_hold c=%0d: got valid/page/x %0b/%0d/%0h required 1/0/%0h", c, if_a.UpdValid,
                             if_a.Page, if_a.DataX, word_a(DIV_A + 1, 0)); else n_pass++;
            end
        end
        ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            advance();
            c = cyc;
            n_checks++; if (if_a.UpdValid !== ((c == r + 2) || (c == 4*DIV_A + 2)))
                $display("[TB] FAIL bp_valid c=%0d: got %0b", c, if_a.UpdValid); else n_pass++;
            if (c == r + 2) begin
                n_checks++; if ({if_a.Page, if_a.DataX, if_a.DataY} !==
                                {PW_A'((3 / DWELL_A) % PAGES_A), word_a(c - 1, 2*((3 / DWELL_A) % PAGES_A)),
                                 word_a(c - 1, 2*((3 / DWELL_A) % PAGES_A) + 1)})
                    $display("[TB] FAIL bp_coalesced c=%0d: got page/x %0d/%0h required %0d/%0h", c, if_a.Page, if_a.DataX,
                             (3 / DWELL_A) % PAGES_A, word_a(c - 1, 2*((3 / DWELL_A) % PAGES_A))); else n_pass++;
            end
            if (c == 4*DIV_A + 2) begin
                n_checks++; if ({if_a.Page, if_a.DataX} !== {PW_A'((4 / DWELL_A) % PAGES_A), word_a(c - 1, 2*((4 / DWELL_A) % PAGES_A))})
                    $display("[TB] FAIL bp_next c=%0d: got page/x %0d/%0h", c, if_a.Page, if_a.DataX); else n_pass++;
            end
        end
    endtask

    // Reset lands mid-offer with a tick pending; nothing may leak out afterwards.
    task automatic test_reset_mid_offer();
        int c;
        do_reset(MODE_RUN, 1'b0);
        for (int i = 0; i < 3*DIV_A; i++) advance();
        n_checks++; if ({cpu_en_a, if_a.UpdValid} !== 2'b11)
            $display("[TB] FAIL rst_offer_setup: got %0b required 11", {cpu_en_a, if_a.UpdValid}); else n_pass++;
        Rst = 1'b0;
        #1;
        n_checks++; if ({cpu_en_a, if_a.UpdValid, if_a.DataX, if_a.DataY, if_a.Page} !== '0)
            $display("[TB] FAIL rst_offer_clear_a: got %0h required 0", {cpu_en_a, if_a.UpdValid, if_a.DataX, if_a.DataY, if_a.Page}); else n_pass++;
        n_checks++; if ({cpu_en_b, if_b.UpdValid} !== 2'b00)
            $display("[TB] FAIL rst_offer_clear_b: got %0b required 00", {cpu_en_b, if_b.UpdValid}); else n_pass++;
        ready_a = 1'b1;
        release_reset();
        for (int i = 0; i < DIV_A + 2; i++) begin
            advance();
            c = cyc;
            n_checks++; if (if_a.UpdValid !== (c == DIV_A + 2))
                $display("[TB] FAIL rst_offer_after c=%0d: got %0b required %0b", c, if_a.UpdValid, c == DIV_A + 2); else n_pass++;
            if (c == DIV_A + 2) begin
                n_checks++; if ({if_a.Page, if_a.DataX} !== {PW_A'(0), word_a(c - 1, 0)})
                    $display("[TB] FAIL rst_offer_first c=%0d: got page/x %0d/%0h required 0/%0h", c, if_a.Page, if_a.DataX,
                             word_a(c - 1, 0)); else n_pass++;
            end
        end
    endtask

    initial begin
        $display("[TB] debug_display_sequencer bench start");
        test_reset();
        test_run();
        test_step();
        test_halt();
        test_backpressure();
        test_reset_mid_offer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
